mario_sprite_drawer: RTL and testbench

//  Consumer side of the Mario position interface: takes the X/Y position produced by the

---
 rtl/mario_sprite_drawer.sv | 197 +++++++++++++++++++
 tb/tb_mario_sprite_drawer.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/mario_sprite_drawer.sv
// mario_sprite_drawer
//   Takes the Mario top-left position from the position register and redraws
//   the sprite into the 160x120 VGA framebuffer. The sprite at the previously
//   drawn position is first painted over with the background colour. The
//   sprite is then drawn at the new position from a synchronous sprite ROM,
//   one pixel per clock. Pixels that fall off screen are not plotted, but
//   they still take their clock cycle.
//
// Ports
//   clock       in   system clock, rising edge
//   reset       in   asynchronous active-high reset
//   start       in   redraw request, only looked at while idle
//   pos_x/pos_y in   new sprite top-left, captured together with start
//   busy        out  frame update in progress
//   done        out  single-cycle pulse when the update has finished
//   rom_addr    out  sprite ROM address (row*SPR_W + col)
//   rom_data    in   sprite ROM colour, valid one cycle after rom_addr
//   vga_x/vga_y out  registered plot coordinates
//   vga_colour  out  registered plot colour
//   vga_plot    out  plot strobe, one pixel per high cycle
module mario_sprite_drawer #(
    parameter int          SPR_W     = 8,
    parameter int          SPR_H     = 8,
    parameter int          INIT_X    = 4,
    parameter int          INIT_Y    = 89,
    parameter logic [2:0]  BG_COLOUR = 3'b011,
    parameter logic [2:0]  TRANSP    = 3'b000,
    parameter int          SCR_W     = 160,
    parameter int          SCR_H     = 120,
    localparam int         ADDR_W    = $clog2(SPR_W * SPR_H)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        pos_x,
    input  logic [7:0]        pos_y,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [2:0]        rom_data,
    output logic [7:0]        vga_x,
    output logic [6:0]        vga_y,
    output logic [2:0]        vga_colour,
    output logic              vga_plot
);

    localparam int NPIX  = SPR_W * SPR_H;
    localparam int CNT_W = $clog2(NPIX + 2);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ERASE,
        S_DRAW,
        S_DONE
    } state_t;

    state_t             state;
    state_t             next_state;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   next_cnt;
    logic [7:0]         old_x;
    logic [7:0]         old_y;
    logic [7:0]         new_x;
    logic [7:0]         new_y;
    logic               first;

    logic [CNT_W-1:0]   pix_idx;
    logic [CNT_W-1:0]   col;
    logic [CNT_W-1:0]   row;
    logic [7:0]         base_x;
    logic [7:0]         base_y;
    logic [8:0]         sum_x;
    logic [8:0]         sum_y;
    logic               on_screen;
    logic               draw_slot;
    logic               plot_now;
    logic [2:0]         plot_colour;

    // State and pixel counter register. Reset drops straight back to idle,
    // which abandons any frame that is in progress.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= next_state;
            cnt   <= next_cnt;
        end
    end

    // Next-state logic. In ERASE the counter is the pixel index itself.
    // In DRAW the counter leads the plotted pixel by one, because the ROM
    // needs a cycle to respond. DRAW therefore runs NPIX+2 cycles. The first
    // of these is the pipeline bubble and the last one is the trailing cycle
    // before done.
    always_comb begin
        next_state = state;
        next_cnt   = cnt;
        case (state)
            S_IDLE: begin
                if (start) begin
                    next_state = first ? S_DRAW : S_ERASE;
                    next_cnt   = '0;
                end
            end
            S_ERASE: begin
                if (cnt == CNT_W'(NPIX - 1)) begin
                    next_state = S_DRAW;
                    next_cnt   = '0;
                end else begin
                    next_cnt = cnt + 1'b1;
                end
            end
            S_DRAW: begin
                if (cnt == CNT_W'(NPIX + 1)) begin
                    next_state = S_DONE;
                    next_cnt   = '0;
                end else begin
                    next_cnt = cnt + 1'b1;
                end
            end
            S_DONE: begin
                next_state = S_IDLE;
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    // Works out which pixel is being plotted this cycle and where it lands.
    // Coordinates are added at 9 bits, so an off-screen pixel is clipped
    // rather than wrapped round to the left or top edge.
    always_comb begin
        pix_idx     = (state == S_DRAW) ? cnt - 1'b1 : cnt;
        col         = pix_idx % CNT_W'(SPR_W);
        row         = pix_idx / CNT_W'(SPR_W);
        base_x      = (state == S_DRAW) ? new_x : old_x;
        base_y      = (state == S_DRAW) ? new_y : old_y;
        sum_x       = {1'b0, base_x} + 9'(col);
        sum_y       = {1'b0, base_y} + 9'(row);
        on_screen   = (sum_x < 9'(SCR_W)) && (sum_y < 9'(SCR_H));
        draw_slot   = (state == S_DRAW) && (cnt != '0) && (cnt <= CNT_W'(NPIX));
        plot_now    = ((state == S_ERASE) && on_screen) ||
                      (draw_slot && on_screen && (rom_data != TRANSP));
        plot_colour = (state == S_ERASE) ? BG_COLOUR : rom_data;
    end

    assign busy = (state == S_ERASE) || (state == S_DRAW);
    assign done = (state == S_DONE);

    // Position bookkeeping. The new position is frozen when a redraw is
    // accepted. It becomes the "old" position only once the frame has
    // finished, so a reset mid-frame leaves the next frame treated as the
    // first one.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            old_x <= 8'(INIT_X);
            old_y <= 8'(INIT_Y);
            new_x <= '0;
            new_y <= '0;
            first <= 1'b1;
        end else begin
            if (state == S_IDLE && start) begin
                new_x <= pos_x;
                new_y <= pos_y;
            end
            if (state == S_DONE) begin
                old_x <= new_x;
                old_y <= new_y;
                first <= 1'b0;
            end
        end
    end

    // Plot port and ROM address registers. The coordinates and colour change
    // only on a real plot, so clipped positions never show up on vga_x/vga_y.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            vga_plot   <= 1'b0;
            vga_x      <= '0;
            vga_y      <= '0;
            vga_colour <= '0;
            rom_addr   <= '0;
        end else begin
            vga_plot <= plot_now;
            if (plot_now) begin
                vga_x      <= sum_x[7:0];
                vga_y      <= sum_y[6:0];
                vga_colour <= plot_colour;
            end
            rom_addr <= (next_state == S_DRAW && next_cnt < CNT_W'(NPIX))
                        ? next_cnt[ADDR_W-1:0] : '0;
        end
    end

endmodule

// File: tb/tb_mario_sprite_drawer.sv
// tb_mario_sprite_drawer
//   Directed-plus-random bench for mario_sprite_drawer. A synchronous sprite
//   ROM model feeds the design. A cycle-indexed reference model predicts
//   every plot, done and busy value from the frame timing rules.
module tb_mario_sprite_drawer;

    localparam int N    = 64;
    localparam int SW   = 8;
    localparam int BG   = 3;
    localparam int INIX = 4;
    localparam int INIY = 89;

    logic       clock = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] pos_x;
    logic [7:0] pos_y;
    logic       busy;
    logic       done;
    logic [5:0] rom_addr;
    logic [2:0] rom_data;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;
    logic       vga_plot;

    logic [2:0] rom [N];

    int checks   = 0;
    int failures = 0;

    bit m_first;
    int m_old_x;
    int m_old_y;

    mario_sprite_drawer dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .pos_x      (pos_x),
        .pos_y      (pos_y),
        .busy       (busy),
        .done       (done),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .vga_x      (vga_x),
        .vga_y      (vga_y),
        .vga_colour (vga_colour),
        .vga_plot   (vga_plot)
    );

    always #5 clock = ~clock;

    // Synchronous sprite ROM: data follows the address by one clock.
    always @(posedge clock) rom_data <= rom[rom_addr];

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, " busy"},     32'(busy),       32'd0);
        checkOutput({tag, " done"},     32'(done),       32'd0);
        checkOutput({tag, " plot"},     32'(vga_plot),   32'd0);
        checkOutput({tag, " x"},        32'(vga_x),      32'd0);
        checkOutput({tag, " y"},        32'(vga_y),      32'd0);
        checkOutput({tag, " colour"},   32'(vga_colour), 32'd0);
        checkOutput({tag, " rom_addr"}, 32'(rom_addr),   32'd0);
    endtask

    task automatic fillRom(input bit all_transp);
        for (int i = 0; i < N; i++)
            rom[i] = all_transp ? 3'b000 : 3'($urandom_range(0, 7));
    endtask

    // Runs one frame and checks every cycle against the model.
    // In frame-relative terms, start is sampled at edge t and cycle j is the
    // interval after edge t+j. The erase of pixel k shows at j=1+k. Draw
    // pixel k shows at j=base+k, where base is 2 on a first frame and N+2
    // otherwise. done shows at j=base+N.
    task automatic applyStimulus(input string name, input int nx, input int ny,
                                 input bit perturb, input int abort_px);
        int  draw_base;
        int  done_j;
        int  abort_j;
        int  k;
        int  ex;
        int  ey;
        int  ecol;
        bit  eplot;
        @(negedge clock);
        pos_x = 8'(nx);
        pos_y = 8'(ny);
        start = 1'b1;
        @(posedge clock);
        @(negedge clock);
        start     = 1'b0;
        draw_base = m_first ? 2 : N + 2;
        done_j    = draw_base + N;
        abort_j   = (abort_px >= 0) ? draw_base + abort_px : -1;
        for (int j = 1; j <= done_j + 1; j++) begin
            @(negedge clock);
            eplot = 1'b0;
            ex    = 0;
            ey    = 0;
            ecol  = 0;
            if (!m_first && j <= N) begin
                k     = j - 1;
                ex    = m_old_x + k % SW;
                ey    = m_old_y + k / SW;
                ecol  = BG;
                eplot = (ex < 160) && (ey < 120);
            end else if (j >= draw_base && j < draw_base + N) begin
                k     = j - draw_base;
                ex    = nx + k % SW;
                ey    = ny + k / SW;
                ecol  = int'(rom[k]);
                eplot = (ex < 160) && (ey < 120) && (ecol != 0);
            end
            checkOutput({name, " plot"}, 32'(vga_plot), 32'(eplot));
            if (eplot) begin
                checkOutput({name, " x"},      32'(vga_x),      32'(ex));
                checkOutput({name, " y"},      32'(vga_y),      32'(ey));
                checkOutput({name, " colour"}, 32'(vga_colour), 32'(ecol));
            end
            checkOutput({name, " done"}, 32'(done), 32'(j == done_j));
            checkOutput({name, " busy"}, 32'(busy), 32'(j < done_j));
            if (j == abort_j) begin
                reset = 1'b1;
                #1;
                checkAllZero({name, " abort"});
                @(negedge clock);
                reset   = 1'b0;
                m_first = 1'b1;
                m_old_x = INIX;
                m_old_y = INIY;
                return;
            end
            if (perturb && j == 10) begin
                start = 1'b1;
                pos_x = 8'($urandom);
                pos_y = 8'($urandom);
            end
            if (perturb && j == 11) start = 1'b0;
        end
        m_first = 1'b0;
        m_old_x = nx;
        m_old_y = ny;
    endtask

    initial begin
        reset   = 1'b1;
        start   = 1'b0;
        pos_x   = '0;
        pos_y   = '0;
        m_first = 1'b1;
        m_old_x = INIX;
        m_old_y = INIY;
        fillRom(1'b0);
        repeat (3) @(posedge clock);
        @(negedge clock);
        checkAllZero("reset");
        reset = 1'b0;

        applyStimulus("first",  4,   89,  1'b0, -1);
        applyStimulus("step",   5,   89,  1'b0, -1);
        fillRom(1'b1);
        applyStimulus("transp", int'($urandom_range(0, 150)), int'($urandom_range(0, 110)), 1'b0, -1);
        fillRom(1'b0);
        applyStimulus("clip",   156, 116, 1'b0, -1);
        applyStimulus("ignore", 20,  30,  1'b1, -1);
        applyStimulus("abort",  60,  40,  1'b0, 20);
        applyStimulus("rearm",  70,  50,  1'b0, -1);
        applyStimulus("same",   70,  50,  1'b0, -1);
        for (int r = 0; r < 4; r++) begin
            fillRom(1'b0);
            applyStimulus("random", int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                          1'b0, -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
